ex_mem_reg: RTL and testbench
=============================

# ex_mem_reg

EX/MEM pipeline stage register for the pipelined MIPS datapath. Captures the ALU result and zero flag, the store data, the destination register, the branch target and the MEM/WB control bits at the end of the EX stage. Presents them to data memory and to the forwarding unit. Resolves branches with a one-cycle taken pulse, supports stall and flush, and keeps a commit counter for debug.

## Interface
- `CNT_W`, default 16: width of the commit counter.
- `clk_i`  in  1  stage clock; all state updates on rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `stall_i`  in  1  hold all stage contents.
- `flush_i`  in  1  replace stage contents with a bubble.
- `valid_i`  in  1  EX holds a real instruction.
- `alu_result_i`  in  32  ALU result.
- `zero_i`  in  1  ALU zero flag, already branch-polarity adjusted (beq/bne).
- `rt_data_i`  in  32  store data.
- `write_reg_i`  in  5  destination register number.
- `branch_target_i`  in  32  PC+4+(imm<<2).
- `reg_write_i`, `mem_read_i`, `mem_write_i`, `mem_to_reg_i`, `branch_i`  in  1 each  decoded control.
- `valid_o`  out  1  stage holds a real instruction.
- `alu_result_o`  out  32
- `rt_data_o`  out  32
- `write_reg_o`  out  5
- `branch_target_o`  out  32
- `reg_write_o`, `mem_read_o`, `mem_write_o`, `mem_to_reg_o`  out  1 each
- `branch_taken_o`  out  1  one-cycle taken pulse to IF/ID flush logic.
- `commit_cnt_o`  out  `CNT_W`  count of valid instructions loaded.

## Operation
- Update priority each edge: reset > flush > stall > load.
- **Reset.** All outputs are 0, including `commit_cnt_o` and `branch_taken_o`.
- **Flush.** Every registered output is cleared to 0. `commit_cnt_o` is unchanged. Flush wins over a simultaneous stall.
- **Stall.** All registered data, control and `valid_o` hold. `branch_taken_o` still clears: it is never asserted on two consecutive cycles.
- **Load with `valid_i`=1.**
  - All fields are captured.
  - `reg_write_o` = `reg_write_i` & (`write_reg_i` != 0); writes to $zero are suppressed.
  - `mem_read_o` = `mem_read_i` & ~`mem_write_i`; write wins when both are set.
  - `branch_taken_o` = `branch_i` & `zero_i`.
  - `commit_cnt_o` increments by 1, wrapping from all-ones to 0.
- **Load with `valid_i`=0 (bubble).**
  - Data fields are captured as presented.
  - `valid_o`, `reg_write_o`, `mem_read_o`, `mem_write_o`, `mem_to_reg_o` and `branch_taken_o` are forced 0.
  - The counter is unchanged.
- `branch_target_o` is meaningful only while `branch_taken_o`=1.
- No arithmetic on data paths; all 32-bit fields pass unmodified.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- `branch_taken_o` is high for exactly the cycle after the capturing edge. The upstream flush of IF/ID and ID/EX is driven combinationally from it.
- Reset mid-operation:
  - Asynchronous assertion clears outputs immediately, without waiting for a clock.
  - Deassertion is synchronised externally.
  - The first capture happens on the first edge with `rst_i` low.
- `flush_i` and `stall_i` are sampled only at the clock edge; there is no combinational path from them to the outputs.

## Test plan
- **Reset.** Assert `rst_i` between edges with the stage full. All outputs go to 0 before the next edge, and `commit_cnt_o`=0.
- **Load.** Valid add, `alu_result_i`=0x0000_0010, `write_reg_i`=8, `reg_write_i`=1.
  - After the edge: `alu_result_o`=0x10, `write_reg_o`=8, `reg_write_o`=1, `valid_o`=1, `commit_cnt_o`=1.
  - Same with `write_reg_i`=0: `reg_write_o`=0.
- **Branch pulse.** Valid beq with `branch_i`=1, `zero_i`=1, `branch_target_i`=0x40, then `stall_i`=1 for 3 cycles.
  - `branch_taken_o`=1 for one cycle only; `branch_target_o` holds 0x40 throughout.
  - With `zero_i`=0 instead: no pulse.
- **Flush vs stall.** `flush_i`=1 and `stall_i`=1 on the same edge with a valid sw in the stage. `valid_o`=0, `mem_write_o`=0 and the counter is unchanged.
- **Bubble and illegal control.**
  - `valid_i`=0 with `mem_write_i`=1: `mem_write_o`=0 and the counter holds.
  - `valid_i`=1 with `mem_read_i`=`mem_write_i`=1: `mem_write_o`=1, `mem_read_o`=0.
- **Counter wrap.** With `CNT_W`=4, load 17 valid instructions: `commit_cnt_o` reads 15 after the 15th load, then 0, then 1 after the 17th.

Source files
------------

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline stage register: captures EX results and MEM/WB control,
// resolves branches as a one-cycle taken pulse, supports stall/flush and
// counts committed (valid) loads for debug.
module ex_mem_reg #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [31:0]      alu_result_i,
  input  logic             zero_i,
  input  logic [31:0]      rt_data_i,
  input  logic [4:0]       write_reg_i,
  input  logic [31:0]      branch_target_i,
  input  logic             reg_write_i,
  input  logic             mem_read_i,
  input  logic             mem_write_i,
  input  logic             mem_to_reg_i,
  input  logic             branch_i,
  output logic             valid_o,
  output logic [31:0]      alu_result_o,
  output logic [31:0]      rt_data_o,
  output logic [4:0]       write_reg_o,
  output logic [31:0]      branch_target_o,
  output logic             reg_write_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             mem_to_reg_o,
  output logic             branch_taken_o,
  output logic [CNT_W-1:0] commit_cnt_o
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             valid_q, valid_d;
  logic [31:0]      alu_result_q, alu_result_d;
  logic [31:0]      rt_data_q, rt_data_d;
  logic [4:0]       write_reg_q, write_reg_d;
  logic [31:0]      branch_target_q, branch_target_d;
  logic             reg_write_q, reg_write_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic             mem_to_reg_q, mem_to_reg_d;
  logic             branch_taken_q, branch_taken_d;
  logic [CNT_W-1:0] commit_cnt_q, commit_cnt_d;

  // Next-state: flush > stall > load; taken pulse clears unless freshly loaded.
  always_comb begin
    valid_d         = valid_q;
    alu_result_d    = alu_result_q;
    rt_data_d       = rt_data_q;
    write_reg_d     = write_reg_q;
    branch_target_d = branch_target_q;
    reg_write_d     = reg_write_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_to_reg_d    = mem_to_reg_q;
    branch_taken_d  = 1'b0;
    commit_cnt_d    = commit_cnt_q;

    if (flush_i) begin
      valid_d         = 1'b0;
      alu_result_d    = '0;
      rt_data_d       = '0;
      write_reg_d     = '0;
      branch_target_d = '0;
      reg_write_d     = 1'b0;
      mem_read_d      = 1'b0;
      mem_write_d     = 1'b0;
      mem_to_reg_d    = 1'b0;
    end else if (!stall_i) begin
      // Data fields pass through even for bubbles; control is gated by valid.
      alu_result_d    = alu_result_i;
      rt_data_d       = rt_data_i;
      write_reg_d     = write_reg_i;
      branch_target_d = branch_target_i;
      valid_d         = valid_i;
      reg_write_d     = valid_i & reg_write_i & (write_reg_i != 5'd0);
      // Store wins over a conflicting load request.
      mem_read_d      = valid_i & mem_read_i & ~mem_write_i;
      mem_write_d     = valid_i & mem_write_i;
      mem_to_reg_d    = valid_i & mem_to_reg_i;
      branch_taken_d  = valid_i & branch_i & zero_i;
      if (valid_i) begin
        commit_cnt_d = commit_cnt_q + CntOne;
      end
    end
  end

  // Stage state register with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q         <= 1'b0;
      alu_result_q    <= '0;
      rt_data_q       <= '0;
      write_reg_q     <= '0;
      branch_target_q <= '0;
      reg_write_q     <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      branch_taken_q  <= 1'b0;
      commit_cnt_q    <= '0;
    end else begin
      valid_q         <= valid_d;
      alu_result_q    <= alu_result_d;
      rt_data_q       <= rt_data_d;
      write_reg_q     <= write_reg_d;
      branch_target_q <= branch_target_d;
      reg_write_q     <= reg_write_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_to_reg_q    <= mem_to_reg_d;
      branch_taken_q  <= branch_taken_d;
      commit_cnt_q    <= commit_cnt_d;
    end
  end

  assign valid_o         = valid_q;
  assign alu_result_o    = alu_result_q;
  assign rt_data_o       = rt_data_q;
  assign write_reg_o     = write_reg_q;
  assign branch_target_o = branch_target_q;
  assign reg_write_o     = reg_write_q;
  assign mem_read_o      = mem_read_q;
  assign mem_write_o     = mem_write_q;
  assign mem_to_reg_o    = mem_to_reg_q;
  assign branch_taken_o  = branch_taken_q;
  assign commit_cnt_o    = commit_cnt_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: stimulus pushes expected stage contents,
// an independent monitor pops and compares one entry per clock edge.
module tb_ex_mem_reg;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst, stall, flush, valid, zero;
  logic [31:0]   alu, rt, tgt;
  logic [4:0]    wr;
  logic          rw, mr, mw, m2r, br;
  logic          valid_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, branch_taken_o;
  logic [31:0]   alu_result_o, rt_data_o, branch_target_o;
  logic [4:0]    write_reg_o;
  logic [CW-1:0] commit_cnt_o;

  typedef struct packed {
    logic        rst, stall, flush, valid, zero;
    logic [31:0] alu, rt, tgt;
    logic [4:0]  wr;
    logic        rw, mr, mw, m2r, br;
  } in_t;

  typedef struct packed {
    logic          v;
    logic [31:0]   alu, rt, tgt;
    logic [4:0]    wr;
    logic          rw, mr, mw, m2r, bt;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t model;
  int   vectors = 0;
  int   miscompares = 0;

  ex_mem_reg #(.CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(valid),
    .alu_result_i(alu), .zero_i(zero), .rt_data_i(rt), .write_reg_i(wr),
    .branch_target_i(tgt), .reg_write_i(rw), .mem_read_i(mr), .mem_write_i(mw),
    .mem_to_reg_i(m2r), .branch_i(br), .valid_o(valid_o), .alu_result_o(alu_result_o),
    .rt_data_o(rt_data_o), .write_reg_o(write_reg_o), .branch_target_o(branch_target_o),
    .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_to_reg_o(mem_to_reg_o), .branch_taken_o(branch_taken_o),
    .commit_cnt_o(commit_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input exp_t e);
    chk("valid_o", 32'(valid_o), 32'(e.v));
    chk("alu_result_o", alu_result_o, e.alu);
    chk("rt_data_o", rt_data_o, e.rt);
    chk("write_reg_o", 32'(write_reg_o), 32'(e.wr));
    chk("branch_target_o", branch_target_o, e.tgt);
    chk("reg_write_o", 32'(reg_write_o), 32'(e.rw));
    chk("mem_read_o", 32'(mem_read_o), 32'(e.mr));
    chk("mem_write_o", 32'(mem_write_o), 32'(e.mw));
    chk("mem_to_reg_o", 32'(mem_to_reg_o), 32'(e.m2r));
    chk("branch_taken_o", 32'(branch_taken_o), 32'(e.bt));
    chk("commit_cnt_o", 32'(commit_cnt_o), 32'(e.cnt));
  endtask

  // Reference behaviour of one clock edge, written from the stage rules.
  function automatic exp_t ref_step(input exp_t cur, input in_t s);
    exp_t n = cur;
    if (s.rst) return '0;
    n.bt = 1'b0;
    if (s.flush) begin
      n     = '0;
      n.cnt = cur.cnt;
    end else if (!s.stall) begin
      n.alu = s.alu;
      n.rt  = s.rt;
      n.tgt = s.tgt;
      n.wr  = s.wr;
      n.v   = s.valid;
      n.rw  = s.valid && s.rw && s.wr != 0;
      n.mw  = s.valid && s.mw;
      n.mr  = s.valid && s.mr && !s.mw;
      n.m2r = s.valid && s.m2r;
      n.bt  = s.valid && s.br && s.zero;
      if (s.valid) n.cnt = CW'((int'(cur.cnt) + 1) % (1 << CW));
    end
    return n;
  endfunction

  task automatic issue(input in_t s);
    @(negedge clk);
    rst = s.rst; stall = s.stall; flush = s.flush; valid = s.valid; zero = s.zero;
    alu = s.alu; rt = s.rt; tgt = s.tgt; wr = s.wr;
    rw = s.rw; mr = s.mr; mw = s.mw; m2r = s.m2r; br = s.br;
    model = ref_step(model, s);
    q.push_back(model);
  endtask

  function automatic in_t rand_in();
    in_t s;
    s.rst   = 1'b0;
    s.stall = ($urandom_range(0, 5) == 0);
    s.flush = ($urandom_range(0, 9) == 0);
    s.valid = ($urandom_range(0, 3) != 0);
    s.zero  = 1'($urandom);
    s.alu   = $urandom;
    s.rt    = $urandom;
    s.tgt   = $urandom;
    s.wr    = 5'($urandom);
    s.rw    = 1'($urandom);
    s.mr    = 1'($urandom);
    s.mw    = 1'($urandom);
    s.m2r   = 1'($urandom);
    s.br    = 1'($urandom);
    return s;
  endfunction

  function automatic in_t plain_valid();
    in_t s = rand_in();
    s.stall = 1'b0;
    s.flush = 1'b0;
    s.valid = 1'b1;
    return s;
  endfunction

  // Monitor: the stage presents new contents after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check_all(e);
      end
    end
  end

  initial begin
    in_t s;
    exp_t zero_exp = '0;
    int budget;
    rst = 1'b1; stall = 0; flush = 0; valid = 0; zero = 0;
    alu = 0; rt = 0; tgt = 0; wr = 0; rw = 0; mr = 0; mw = 0; m2r = 0; br = 0;
    model = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all(zero_exp);
    @(negedge clk);
    rst = 1'b0;

    // Valid add to $t0, then the same to $zero.
    s = plain_valid(); s.alu = 32'h10; s.wr = 5'd8; s.rw = 1'b1; s.br = 1'b0;
    issue(s);
    s.wr = 5'd0;
    issue(s);

    // Taken beq held under a 3-cycle stall: single pulse, target held.
    s = plain_valid(); s.br = 1'b1; s.zero = 1'b1; s.tgt = 32'h40;
    issue(s);
    for (int i = 0; i < 3; i++) begin
      s = rand_in(); s.stall = 1'b1; s.flush = 1'b0;
      issue(s);
    end
    // Not-taken beq.
    s = plain_valid(); s.br = 1'b1; s.zero = 1'b0;
    issue(s);
    s = rand_in(); s.stall = 1'b1; s.flush = 1'b0;
    issue(s);

    // Valid sw, then flush and stall together.
    s = plain_valid(); s.mw = 1'b1; s.mr = 1'b0; s.br = 1'b0;
    issue(s);
    s = rand_in(); s.stall = 1'b1; s.flush = 1'b1;
    issue(s);

    // Bubble carrying a store, then conflicting read/write request.
    s = rand_in(); s.stall = 0; s.flush = 0; s.valid = 1'b0; s.mw = 1'b1;
    issue(s);
    s = plain_valid(); s.mr = 1'b1; s.mw = 1'b1;
    issue(s);

    // Asynchronous reset between edges with the stage full.
    s = plain_valid(); s.rw = 1'b1; s.wr = 5'd3;
    issue(s);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all(zero_exp);
    model = '0;
    s = rand_in(); s.rst = 1'b1;
    issue(s);

    // Counter wrap: 17 back-to-back valid loads from zero.
    for (int i = 0; i < 17; i++) issue(plain_valid());

    for (int i = 0; i < 300; i++) issue(rand_in());

    budget = 0;
    while (q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
